// File: rtl/interp_timing_ctrl.sv
// interp_timing_ctrl: NCO timing controller that pulls samples on phase wraps and
// presents coherent x_out/mu pairs to the parabolic interpolator.
module interp_timing_ctrl #(
    parameter int DATA_W    = 13,
    parameter int MU_W      = 13,
    parameter int FRAC_BITS = 11,
    parameter int PHASE_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [PHASE_W-1:0]       step,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] x_out,
    output logic [MU_W-1:0]          mu,
    output logic                     out_strobe,
    output logic                     new_sample,
    output logic                     underrun,
    output logic [15:0]              sample_cnt
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, STALL} state_t;
    state_t state;
    logic [PHASE_W-1:0] phase, step_q;
    logic [PHASE_W:0] sum;
    logic carry, hs;
    assign sum        = {1'b0, phase} + {1'b0, step_q};
    assign carry      = sum[PHASE_W];
    assign in_ready   = state == FILL || state == STALL || (state == RUN && carry);
    assign hs         = in_ready && in_valid;
    assign out_strobe = state == RUN;
    assign mu         = MU_W'(phase[PHASE_W-1 -: FRAC_BITS]);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            step_q     <= '0;
            x_out      <= '0;
            sample_cnt <= '0;
            new_sample <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            new_sample <= hs;
            if (hs) begin
                x_out      <= in_data;
                sample_cnt <= sample_cnt + 16'd1;
            end
            case (state)
                IDLE: if (enable) begin
                    state    <= FILL;
                    step_q   <= step;
                    underrun <= 1'b0;
                end
                FILL: if (in_valid) begin
                    phase <= '0;
                    state <= RUN;
                end
                RUN: begin
                    phase <= sum[PHASE_W-1:0];
                    if (carry && !in_valid) begin
                        underrun <= 1'b1;
                        state    <= STALL;
                    end
                end
                STALL: if (in_valid) state <= RUN;
                default: state <= IDLE;
            endcase
            // dropping enable wins over the transition above, but the handshake still lands
            if (!enable && state != IDLE) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_interp_timing_ctrl.sv
// tb_interp_timing_ctrl: randomized scoreboard bench; expected pairs come from k*step arithmetic.
module tb_interp_timing_ctrl;
    localparam int DW = 13, MW = 13, FB = 11, PW = 24;
    logic clk = 1'b0, rst = 1'b0, enable = 1'b0, in_valid = 1'b0;
    logic [PW-1:0] step = '0;
    logic signed [DW-1:0] in_data = '0;
    logic in_ready, out_strobe, new_sample, underrun;
    logic signed [DW-1:0] x_out;
    logic [MW-1:0] mu;
    logic [15:0] sample_cnt;
    int checks = 0, failures = 0;

    interp_timing_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .step(step), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .x_out(x_out), .mu(mu),
        .out_strobe(out_strobe), .new_sample(new_sample), .underrun(underrun),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_FILL, M_RUN, M_STALL} mode_t;
    typedef struct {
        logic signed [DW-1:0] x;
        logic [MW-1:0] mu;
        logic ns;
        logic und;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    logic signed [DW-1:0] data [8192];
    mode_t m = M_IDLE;
    longint k = 0, s = 0;
    int n = 0, base = 0, mcnt = 0, cbase = 0, drop_left = 0;
    logic und = 1'b0;

    // strobe k of a session shows sample floor(k*s/2^PW) and the fractional part of k*s
    function automatic longint sidx(input longint kk);
        return (kk * s) >> PW;
    endfunction
    function automatic int mu_of(input longint kk);
        return int'(((kk * s) & ((longint'(1) << PW) - 1)) >> (PW - FB));
    endfunction
    function automatic logic wrap(input longint kk);
        return sidx(kk + 1) != sidx(kk);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic en, input int vprob, input logic [PW-1:0] st);
        logic v, w;
        mode_t pm;
        exp_t e;
        @(negedge clk);
        enable = en;
        step = st;
        w = (m == M_RUN) && wrap(k);
        if (drop_left > 0 && (w || m == M_STALL)) begin
            v = 1'b0;
            drop_left--;
        end else v = ($urandom_range(99) < vprob);
        in_valid = v;
        in_data = data[n];
        if (m == M_RUN) begin
            e.x   = data[base + int'(sidx(k))];
            e.mu  = MW'(mu_of(k));
            e.ns  = (k == 0) || (sidx(k) != sidx(k - 1));
            e.und = und;
            e.cnt = 16'(cbase + int'(sidx(k)) + 1);
            q.push_back(e);
        end
        #1;
        chk("in_ready", in_ready, m == M_FILL || m == M_STALL || w);
        chk("out_strobe", out_strobe, m == M_RUN);
        pm = m;
        case (m)
            M_IDLE: if (en) begin
                m = M_FILL;
                s = longint'(st);
                und = 1'b0;
            end
            M_FILL: if (v) begin
                base = n;
                cbase = mcnt;
                n++;
                mcnt++;
                k = 0;
                m = M_RUN;
            end
            M_RUN: begin
                if (w && v) begin
                    n++;
                    mcnt++;
                end
                if (w && !v) begin
                    und = 1'b1;
                    m = M_STALL;
                end
                k++;
            end
            default: if (v) begin
                n++;
                mcnt++;
                m = M_RUN;
            end
        endcase
        if (!en && pm != M_IDLE) m = M_IDLE;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_strobe === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL strobe_unexpected: got out_strobe=1 expected 0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("x_out", x_out, e.x);
                    chk("mu", mu, e.mu);
                    chk("new_sample", new_sample, e.ns);
                    chk("underrun", underrun, e.und);
                    chk("sample_cnt", sample_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int g;
        logic [PW-1:0] st;
        int vp;
        for (int i = 0; i < 8192; i++) data[i] = (i < 64) ? DW'(10 * (i + 1)) : DW'($urandom);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_x_out", x_out, 0);
        chk("rst_mu", mu, 0);
        chk("rst_strobe", out_strobe, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b1;
        // 6x cadence with samples 10, 20, 30, ...
        repeat (40) cyc(1'b1, 100, 24'd2796203);
        // valid held low for 3 cycles starting at the next wrap
        drop_left = 3;
        repeat (24) cyc(1'b1, 100, 24'd2796203);
        // step changes while running are ignored
        repeat (10) cyc(1'b1, 100, 24'($urandom));
        cyc(1'b0, 100, 24'd8388608);
        // 2x cadence latched on re-entry, underrun cleared
        repeat (30) cyc(1'b1, 100, 24'd8388608);
        cyc(1'b0, 100, 24'd2796203);
        g = 0;
        while (!(m == M_RUN && mu_of(k) == 1024) && g < 60) begin
            cyc(1'b1, 100, 24'd2796203);
            g++;
        end
        chk("reach_mu1024", g < 60, 1);
        @(negedge clk);
        #1;
        chk("pre_reset_mu", mu, 1024);
        rst = 1'b0;
        enable = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_x_out", x_out, 0);
        chk("async_mu", mu, 0);
        chk("async_strobe", out_strobe, 0);
        chk("async_new_sample", new_sample, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_cnt", sample_cnt, 0);
        chk("queue_at_reset", q.size(), 0);
        m = M_IDLE;
        mcnt = 0;
        und = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (12) cyc(1'b1, 100, 24'd2796203);
        cyc(1'b0, 100, 24'd0);
        // step 0: never wraps, mu stays 0, no underrun
        repeat (100) cyc(1'b1, 100, 24'd0);
        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(2))
                0: st = 24'($urandom_range(1, 24'hFFFFFF));
                1: st = 24'((32'd1 << 24) / $urandom_range(2, 12));
                default: st = 24'($urandom_range(0, 70000));
            endcase
            vp = int'($urandom_range(50, 100));
            cyc(1'b0, vp, st);
            repeat (150) cyc($urandom_range(99) >= 2, vp, st);
        end
        repeat (3) cyc(1'b0, 0, '0);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
